// File: rtl/sar_logic.sv
// sar_logic: SAR ADC controller (start/polarity_n/comp_out in; sample, comp_en, dac_state, dac_drive_invert, busy out; result valid/ready register with sticky overrun)
module sar_logic #(
  parameter int N_BITS        = 16,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              polarity_n,
  input  logic              comp_out,
  output logic              sample,
  output logic              comp_en,
  output logic [N_BITS-1:0] dac_state,
  output logic              dac_drive_invert,
  output logic              busy,
  output logic [N_BITS-1:0] result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun
);
  localparam int KW = $clog2(N_BITS);
  localparam logic [15:0] S_LAST = 16'(SAMPLE_CYCLES - 1);
  localparam logic [15:0] T_LAST = 16'(SETTLE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, COMP, DECIDE} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [KW-1:0] k;
  logic [N_BITS-1:0] decided;
  always_comb decided = dac_state & ~({{(N_BITS-1){1'b0}}, ~comp_out} << k);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      sample <= 1'b0;
      comp_en <= 1'b0;
      dac_state <= '0;
      dac_drive_invert <= 1'b1;
      busy <= 1'b0;
      result_data <= '0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (result_valid && result_ready) result_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dac_drive_invert <= polarity_n;
          busy <= 1'b1;
          dac_state <= '0;
          sample <= 1'b1;
          cnt <= '0;
          state <= SAMPLE;
        end
        SAMPLE: if (cnt == S_LAST) begin
          sample <= 1'b0;
          dac_state[N_BITS-1] <= 1'b1;
          k <= KW'(N_BITS - 1);
          cnt <= '0;
          state <= TRIAL;
        end else cnt <= cnt + 16'd1;
        TRIAL: if (cnt == T_LAST) begin
          comp_en <= 1'b1;
          cnt <= '0;
          state <= COMP;
        end else cnt <= cnt + 16'd1;
        COMP: begin
          comp_en <= 1'b0;
          state <= DECIDE;
        end
        DECIDE: if (k != '0) begin
          dac_state <= decided | (N_BITS'(1) << (k - KW'(1)));
          k <= k - KW'(1);
          state <= TRIAL;
        end else begin
          dac_state <= decided;
          result_data <= decided;
          result_valid <= 1'b1;
          if (result_valid && !result_ready) overrun <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
